// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bundle between the multicycle controller and its datapath
//
// Purpose: groups the opcode/ready inputs and every control output of the
// multicycle controller so the controller and the datapath share one port.
// Ports (controller view, modport master):
//   in  instr_op_i[5:0]   opcode field from IR
//   in  mem_ready_i       memory completes the current access this cycle
//   out alu_op_o[2:0]     ALUOp to ALU control
//   out alu_src_a_o       0=PC, 1=rs
//   out alu_src_b_o[1:0]  0=rt, 1=4, 2=imm, 3=imm<<2
//   out pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o[1:0]
//   out ir_write_o, i_or_d_o, mem_read_o, mem_write_o
//   out reg_write_o, reg_dst_o, mem_to_reg_o
//   out state_o[3:0], trap_o, trap_cause_o[1:0], instr_count_o[CNT_W-1:0]
// The datapath side uses modport slave.

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       instr_op_i;
    logic             mem_ready_i;
    logic [2:0]       alu_op_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             branch_ne_o;
    logic [1:0]       pc_source_o;
    logic             ir_write_o;
    logic             i_or_d_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             reg_write_o;
    logic             reg_dst_o;
    logic             mem_to_reg_o;
    logic [3:0]       state_o;
    logic             trap_o;
    logic [1:0]       trap_cause_o;
    logic [CNT_W-1:0] instr_count_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output alu_op_o, alu_src_a_o, alu_src_b_o,
        output pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o,
        output ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
        output reg_write_o, reg_dst_o, mem_to_reg_o,
        output state_o, trap_o, trap_cause_o, instr_count_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  alu_op_o, alu_src_a_o, alu_src_b_o,
        input  pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o,
        input  ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
        input  reg_write_o, reg_dst_o, mem_to_reg_o,
        input  state_o, trap_o, trap_cause_o, instr_count_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a shared multicycle datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback one instruction at
// a time, waits on the memory ready handshake and traps on illegal opcodes or
// on a memory access that stays unready for MEM_TIMEOUT consecutive cycles.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-low reset
//   bus    multicycle_ctrl_if.master (opcode/ready in, all controls out)
// Parameters:
//   MEM_TIMEOUT  max consecutive unready cycles in a memory wait state (>=2)
//   CNT_W        width of the retired-instruction counter

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_RTYPE = 3'd0;
    localparam logic [2:0] ALU_ADDI  = 3'd1;
    localparam logic [2:0] ALU_SLTIU = 3'd2;
    localparam logic [2:0] ALU_BEQ   = 3'd3;
    localparam logic [2:0] ALU_LUI   = 3'd4;
    localparam logic [2:0] ALU_ORI   = 3'd5;
    localparam logic [2:0] ALU_BNE   = 3'd6;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The counter only needs to reach MEM_TIMEOUT-1: the MEM_TIMEOUT-th
    // unready cycle is detected while it holds that value.
    localparam int              WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Registered control word. 'fetch' marks the FETCH state; the IR and PC
    // write strobes there are qualified by mem_ready_i at the output.
    typedef struct packed {
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       trap;
    } ctrl_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cause_q, cause_d;
    ctrl_t              ctrl_q;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTIU: imm_alu_op = ALU_SLTIU;
            OP_LUI:   imm_alu_op = ALU_LUI;
            OP_ORI:   imm_alu_op = ALU_ORI;
            default:  imm_alu_op = ALU_ADDI;
        endcase
    endfunction

    // Control word for the state about to be entered, so outputs are
    // registered alongside the state itself.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.src_b    = 2'd1;
                c.alu_op   = ALU_ADDI;
                c.fetch    = 1'b1;
            end
            S_DECODE: begin
                c.src_b  = 2'd3;
                c.alu_op = ALU_ADDI;
            end
            S_MEM_ADDR: begin
                c.src_a  = 1'b1;
                c.src_b  = 2'd2;
                c.alu_op = ALU_ADDI;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.src_a  = 1'b1;
                c.alu_op = ALU_RTYPE;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                c.src_a  = 1'b1;
                c.src_b  = 2'd2;
                c.alu_op = imm_alu_op(op);
            end
            S_I_WB: begin
                c.src_a     = 1'b1;
                c.src_b     = 2'd2;
                c.alu_op    = imm_alu_op(op);
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.src_a         = 1'b1;
                c.alu_op        = (op == OP_BNE) ? ALU_BNE : ALU_BEQ;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'd1;
                c.branch_ne     = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            S_TRAP: begin
                c.trap = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    logic in_wait;
    logic timed_out;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        in_wait   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        // Completion wins over timeout when ready arrives in the last cycle.
        timed_out = in_wait && !bus.mem_ready_i && (wait_q == WAIT_LAST);

        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                op_d = bus.instr_op_i;
                case (bus.instr_op_i)
                    OP_RTYPE:                          state_d = S_R_EXEC;
                    OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: state_d = S_I_EXEC;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready_i) begin
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase

        // Every arrival in FETCH other than from IDLE retires an instruction.
        if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait && !bus.mem_ready_i) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            cause_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_for(state_d, op_d);
        end
    end

    logic fetch_done;
    assign fetch_done = ctrl_q.fetch & bus.mem_ready_i;

    assign bus.alu_op_o        = ctrl_q.alu_op;
    assign bus.alu_src_a_o     = ctrl_q.src_a;
    assign bus.alu_src_b_o     = ctrl_q.src_b;
    assign bus.pc_write_o      = ctrl_q.pc_write | fetch_done;
    assign bus.pc_write_cond_o = ctrl_q.pc_write_cond;
    assign bus.branch_ne_o     = ctrl_q.branch_ne;
    assign bus.pc_source_o     = ctrl_q.pc_source;
    assign bus.ir_write_o      = fetch_done;
    assign bus.i_or_d_o        = ctrl_q.i_or_d;
    assign bus.mem_read_o      = ctrl_q.mem_read;
    assign bus.mem_write_o     = ctrl_q.mem_write;
    assign bus.reg_write_o     = ctrl_q.reg_write;
    assign bus.reg_dst_o       = ctrl_q.reg_dst;
    assign bus.mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign bus.state_o         = state_q;
    assign bus.trap_o          = ctrl_q.trap;
    assign bus.trap_cause_o    = cause_q;
    assign bus.instr_count_o   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

    localparam int TO = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
    } step_t;

    step_t tr[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    exp_count = 0;
    logic [1:0] exp_cause = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000,
            6'b001011, 6'b001101, 6'b001111, 6'b100011, 6'b101011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected control outputs per state, taken straight from the state table.
    function automatic logic [31:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                             input logic rdy, input logic [1:0] cause);
        logic trap, sa, pw, pwc, bne, irw, iod, mr, mw, rw, rd, m2r;
        logic [2:0] alu;
        logic [1:0] sb, ps;
        {trap, sa, pw, pwc, bne, irw, iod, mr, mw, rw, rd, m2r} = '0;
        alu = 3'd0; sb = 2'd0; ps = 2'd0;
        case (st)
            4'd1:  begin mr = 1; sb = 1; alu = 1; irw = rdy; pw = rdy; end
            4'd2:  begin sb = 3; alu = 1; end
            4'd3:  begin sa = 1; sb = 2; alu = 1; end
            4'd4:  begin mr = 1; iod = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iod = 1; end
            4'd7:  begin sa = 1; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9, 4'd10: begin
                sa = 1; sb = 2;
                alu = (op == 6'b001011) ? 3'd2 : (op == 6'b001111) ? 3'd4 :
                      (op == 6'b001101) ? 3'd5 : 3'd1;
                rw = (st == 4'd10);
            end
            4'd11: begin sa = 1; alu = (op == 6'b000101) ? 3'd6 : 3'd3; pwc = 1; ps = 1;
                         bne = (op == 6'b000101); end
            4'd12: begin pw = 1; ps = 2; end
            4'd13: begin trap = 1; end
            default: ;
        endcase
        return 32'({trap, cause, alu, sa, sb, pw, pwc, bne, ps, irw, iod, mr, mw, rw, rd, m2r});
    endfunction

    function automatic logic [31:0] obs_ctrl();
        return 32'({bus.trap_o, bus.trap_cause_o, bus.alu_op_o, bus.alu_src_a_o, bus.alu_src_b_o,
                    bus.pc_write_o, bus.pc_write_cond_o, bus.branch_ne_o, bus.pc_source_o,
                    bus.ir_write_o, bus.i_or_d_o, bus.mem_read_o, bus.mem_write_o,
                    bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o});
    endfunction

    task automatic push_fixed(input logic [3:0] st);
        step_t s;
        s.st  = st;
        s.rdy = 1'($urandom);
        tr.push_back(s);
    endtask

    // w unready cycles then one ready cycle; w >= TO ends in a timeout.
    task automatic push_wait(input logic [3:0] st, input int w, output bit to);
        step_t s;
        int n;
        n = (w >= TO) ? TO : w;
        s.st = st;
        s.rdy = 1'b0;
        for (int i = 0; i < n; i++) tr.push_back(s);
        to = (w >= TO);
        if (!to) begin
            s.rdy = 1'b1;
            tr.push_back(s);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready_i = 1'b1;
        #1;
        check_eq("rst_state", 32'(bus.state_o), 32'd0);
        check_eq("rst_ctrl", obs_ctrl(), 32'd0);
        check_eq("rst_count", 32'(bus.instr_count_o), 32'd0);
        exp_count = 0;
        exp_cause = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_state", 32'(bus.state_o), 32'd0);
        check_eq("idle_ctrl", obs_ctrl(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Builds the expected per-cycle trace of one instruction and replays it.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                             input int hold, input int abort_at);
        bit to;
        logic [1:0] cause;
        tr = {};
        cause = 2'b00;
        push_wait(4'd1, wf, to);
        if (to) cause = 2'b10;
        else begin
            push_fixed(4'd2);
            case (op)
                6'b000000: begin push_fixed(4'd7); push_fixed(4'd8); end
                6'b001000, 6'b001011, 6'b001101, 6'b001111: begin push_fixed(4'd9); push_fixed(4'd10); end
                6'b100011: begin
                    push_fixed(4'd3); push_wait(4'd4, wm, to);
                    if (to) cause = 2'b10; else push_fixed(4'd5);
                end
                6'b101011: begin
                    push_fixed(4'd3); push_wait(4'd6, wm, to);
                    if (to) cause = 2'b10;
                end
                6'b000100, 6'b000101: push_fixed(4'd11);
                6'b000010: push_fixed(4'd12);
                default: cause = 2'b01;
            endcase
        end
        for (int i = 0; i < tr.size(); i++) begin
            bus.instr_op_i  = (tr[i].st == 4'd2) ? op : 6'($urandom);
            bus.mem_ready_i = tr[i].rdy;
            @(negedge clk);
            check_eq($sformatf("st_%0h_%0d", op, i), 32'(bus.state_o), 32'(tr[i].st));
            check_eq($sformatf("ctl_%0h_%0d", op, i), obs_ctrl(),
                     exp_ctrl(tr[i].st, op, tr[i].rdy, exp_cause));
            if (i == abort_at) begin
                #1;
                do_reset();
                return;
            end
            @(posedge clk);
            #1;
        end
        if (cause != 2'b00) begin
            exp_cause = cause;
            for (int i = 0; i < hold; i++) begin
                bus.instr_op_i  = 6'($urandom);
                bus.mem_ready_i = 1'($urandom);
                @(negedge clk);
                check_eq("trap_state", 32'(bus.state_o), 32'd13);
                check_eq("trap_ctrl", obs_ctrl(), exp_ctrl(4'd13, op, 1'b0, exp_cause));
                check_eq("trap_count", 32'(bus.instr_count_o), 32'(exp_count));
                @(posedge clk);
                #1;
            end
            do_reset();
        end else begin
            exp_count = (exp_count + 1) % (1 << CW);
            check_eq("count", 32'(bus.instr_count_o), 32'(exp_count));
        end
    endtask

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000,
                                   6'b001011, 6'b001101, 6'b001111, 6'b100011, 6'b101011};

    initial begin
        logic [5:0] op;
        bus.instr_op_i  = 6'd0;
        bus.mem_ready_i = 1'b1;
        do_reset();

        run_instr(6'b000000, 0, 0, 0, -1);
        run_instr(6'b100011, 0, 3, 0, -1);
        run_instr(6'b000101, 0, 0, 0, -1);
        run_instr(6'b000100, 1, 0, 0, -1);
        run_instr(6'b001011, 0, 0, 0, -1);
        run_instr(6'b001111, 0, 0, 0, -1);
        run_instr(6'b000010, 0, 0, 0, -1);
        run_instr(6'b111111, 0, 0, 100, -1);
        run_instr(6'b000000, TO, 0, 3, -1);
        run_instr(6'b000000, TO - 1, 0, 0, -1);
        run_instr(6'b100011, 0, TO, 3, -1);
        run_instr(6'b101011, 2, TO - 1, 0, -1);
        run_instr(6'b101011, 0, 5, 0, 5);
        run_instr(6'b000000, 0, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
                run_instr(op, $urandom_range(0, 3), 0, 3, -1);
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
                run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared multicycle datapath (PC, IR, register file, single ALU, unified memory) one instruction at a time. It decodes the 6-bit opcode and drives the 3-bit ALUOp into the ALU control block, the mux selects, and the write enables for each step. It waits on a memory ready handshake, and traps on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive cycles with mem_ready_i low in a memory wait state before trapping (≥2)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
instr_op_i  in  6  opcode field from IR
mem_ready_i  in  1  memory completes the current access this cycle
alu_op_o  out  3  ALUOp: R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6
alu_src_a_o  out  1  0=PC, 1=rs register
alu_src_b_o  out  2  0=rt, 1=const 4, 2=extended imm, 3=extended imm<<2
pc_write_o  out  1  unconditional PC write
pc_write_cond_o  out  1  PC write if branch condition met
branch_ne_o  out  1  condition is not-equal (bne)
pc_source_o  out  2  0=ALU result, 1=ALUOut, 2=jump target
ir_write_o  out  1  IR load
i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
reg_write_o  out  1  register file write
reg_dst_o  out  1  1=rd, 0=rt
mem_to_reg_o  out  1  1=MDR, 0=ALUOut
state_o  out  4  current state code
trap_o  out  1  controller halted
trap_cause_o  out  2  01=illegal opcode, 10=memory timeout
instr_count_o  out  CNT_W  retired instructions, wraps

Behaviour:
- States and codes: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, TRAP=13.
- Reset (async, rst_i=0): state=IDLE, op_q=0, wait counter=0, instr_count_o=0, trap_cause_o=0. Every output not listed for a state is 0. IDLE drives all outputs 0 and goes to FETCH after 1 cycle.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=1, alu_op=ADDI. Stays in FETCH while mem_ready_i=0. In the cycle mem_ready_i=1, ir_write=1, pc_write=1, pc_source=0, and the next state is DECODE. ir_write and pc_write are gated by mem_ready_i.
- DECODE: latches op_q<=instr_op_i. Drives src_a=0, src_b=3, alu_op=ADDI (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 001000, 001011, 001111, 001101 (addi, sltiu, lui, ori) → I_EXEC
  - 100011, 101011 (lw, sw) → MEM_ADDR
  - 000100, 000101 (beq, bne) → BRANCH
  - 000010 (j) → JUMP
  - any other opcode → TRAP with cause 01
- R_EXEC: src_a=1, src_b=0, alu_op=R_TYPE, then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- I_EXEC: src_a=1, src_b=2. alu_op is ADDI, SLTIU, LUI or ORI according to op_q. Next state I_WB.
- I_WB: holds the same alu_op and src selects, drives reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=ADDI. Next state is MEM_RD if op_q=lw, MEM_WR if op_q=sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready_i, then MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready_i, then FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=BEQ (beq) or BNE (bne), pc_write_cond=1, pc_source=1, branch_ne=1 for bne only. Next state FETCH.
- JUMP: pc_write=1, pc_source=2, then FETCH.
- Timeout, in wait states (FETCH, MEM_RD, MEM_WR):
  - The wait counter clears on entry to any wait state and increments each cycle mem_ready_i=0.
  - If mem_ready_i=0 in the MEM_TIMEOUT-th consecutive waiting cycle, the next state is TRAP with cause 10.
  - mem_ready_i=1 in that same cycle completes the access normally; completion wins.
- TRAP: trap_o=1, all other controls 0, trap_cause_o held. Left only by reset.
- instr_count_o increments by 1 on every transition into FETCH from R_WB, I_WB, MEM_WB, MEM_WR, BRANCH or JUMP. It wraps at 2^CNT_W.
- Reset asserted mid-instruction aborts immediately to IDLE; no partial write enable is asserted after rst_i falls.
- Latency with mem_ready_i tied high: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3.

Test Plan:
- Reset release, mem_ready_i=1, opcode 000000: state_o follows 0,1,2,7,8,1; alu_op_o=0 in R_EXEC; reg_write_o=1 with reg_dst_o=1 in R_WB only; instr_count_o=1.
- lw (100011) with mem_ready_i low for 3 cycles in MEM_RD: mem_read_o and i_or_d_o stay 1 for 4 cycles; MEM_WB has mem_to_reg_o=1; total 8 cycles from FETCH to FETCH.
- bne (000101): BRANCH drives alu_op_o=6, pc_write_cond_o=1, branch_ne_o=1, pc_source_o=1. beq (000100): alu_op_o=3, branch_ne_o=0.
- Opcodes 001011 and 001111: I_EXEC alu_op_o is 2 and 4 respectively. Opcode 111111: TRAP with trap_o=1, trap_cause_o=01; state stays 13 for 100 cycles.
- MEM_TIMEOUT=16, mem_ready_i held 0 in FETCH: TRAP entered after 16 cycles with cause 10. Rerun with ready rising in cycle 16: normal DECODE.
- rst_i pulsed low during MEM_WR: all outputs 0 asynchronously, state_o=0, instr_count_o=0; execution restarts at FETCH.
